// File: rtl/keypad_scanner.sv
// ============================================================================
//  Module      : keypad_scanner
//  Description : Row-scanning, debouncing decoder for a 4x3 membrane keypad.
//                Produces a held-level one-hot digit vector, active-low
//                start/clear levels, a key code and a one-cycle press strobe.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
   parameter int SCAN_DIV        = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic       clock,
   input  logic       reset_,
   input  logic [2:0] col_,
   output logic [3:0] row_drive_,
   output logic [9:0] keypad,
   output logic       start_,
   output logic       clear_,
   output logic [3:0] key_code,
   output logic       key_strobe
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   // The DEBOUNCE_CYCLES-th stable sample is the one that lands on CNT_LAST.
   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      S_SCAN     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_HELD     = 2'd2,
      S_RELEASE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      sync1_q, cs_q;
   logic [1:0]      row_q, row_d;
   logic [3:0]      row_drive_q, row_drive_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      pat_q, pat_d;
   logic [9:0]      keypad_q, keypad_d;
   logic            start_q, start_d;
   logic            clear_q, clear_d;
   logic [3:0]      code_q, code_d;
   logic            strobe_q, strobe_d;

   logic [1:0]      col_idx;
   logic [3:0]      key_dec;
   logic            one_low;

   // Two-flop synchronizer for the asynchronous column sense lines.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         sync1_q <= 3'b111;
         cs_q    <= 3'b111;
      end else begin
         sync1_q <= col_;
         cs_q    <= sync1_q;
      end
   end

   // Decode the captured row/column pattern into a key code.
   always_comb begin
      col_idx = 2'd0;
      if (!pat_q[1]) begin
         col_idx = 2'd1;
      end else if (!pat_q[2]) begin
         col_idx = 2'd2;
      end
      one_low = (cs_q == 3'b110) || (cs_q == 3'b101) || (cs_q == 3'b011);
      if (row_q == 2'd3) begin
         case (col_idx)
            2'd0:    key_dec = 4'd10;
            2'd1:    key_dec = 4'd0;
            default: key_dec = 4'd11;
         endcase
      end else begin
         key_dec = ({2'b00, row_q} * 4'd3) + {2'b00, col_idx} + 4'd1;
      end
   end

   // Scan / debounce / hold / release sequencing and output next values.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      dwell_d  = dwell_q;
      cnt_d    = cnt_q;
      pat_d    = pat_q;
      keypad_d = keypad_q;
      start_d  = start_q;
      clear_d  = clear_q;
      code_d   = code_q;
      strobe_d = 1'b0;
      case (state_q)
         S_SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (one_low) begin
                  pat_d   = cs_q;
                  cnt_d   = '0;
                  state_d = S_DEBOUNCE;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         S_DEBOUNCE: begin
            if (cs_q != pat_q) begin
               cnt_d   = '0;
               dwell_d = '0;
               state_d = S_SCAN;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_HELD;
               strobe_d = 1'b1;
               code_d   = key_dec;
               keypad_d = '0;
               start_d  = 1'b1;
               clear_d  = 1'b1;
               if (key_dec < 4'd10) begin
                  keypad_d = 10'd1 << key_dec;
               end else if (key_dec == 4'd10) begin
                  clear_d = 1'b0;
               end else begin
                  start_d = 1'b0;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HELD: begin
            if (cs_q == 3'b111) begin
               cnt_d   = '0;
               state_d = S_RELEASE;
            end
         end
         default: begin
            // Release: a return of the original pattern is just contact bounce.
            if (cs_q == pat_q) begin
               state_d = S_HELD;
            end else if (cs_q == 3'b111) begin
               if (cnt_q == CNT_LAST) begin
                  state_d  = S_SCAN;
                  cnt_d    = '0;
                  dwell_d  = '0;
                  row_d    = row_q + 1'b1;
                  keypad_d = '0;
                  start_d  = 1'b1;
                  clear_d  = 1'b1;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
      row_drive_d = ~(4'b0001 << row_d);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q     <= S_SCAN;
         row_q       <= 2'd0;
         row_drive_q <= 4'b1110;
         dwell_q     <= '0;
         cnt_q       <= '0;
         pat_q       <= 3'b111;
         keypad_q    <= '0;
         start_q     <= 1'b1;
         clear_q     <= 1'b1;
         code_q      <= 4'd0;
         strobe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         row_drive_q <= row_drive_d;
         dwell_q     <= dwell_d;
         cnt_q       <= cnt_d;
         pat_q       <= pat_d;
         keypad_q    <= keypad_d;
         start_q     <= start_d;
         clear_q     <= clear_d;
         code_q      <= code_d;
         strobe_q    <= strobe_d;
      end
   end

   assign row_drive_ = row_drive_q;
   assign keypad     = keypad_q;
   assign start_     = start_q;
   assign clear_     = clear_q;
   assign key_code   = code_q;
   assign key_strobe = strobe_q;

endmodule

`default_nettype wire
